// File: rtl/regfile_pipe.sv
// Dual-write, dual-read register file with write-first forwarding, an optional
// hardwired zero register and a per-register busy scoreboard.
module regfile_pipe #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 4,
   parameter bit ZERO_REG = 1'b0
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              WriteEnable0,
   input  logic [ADDR_W-1:0] SelectIn0,
   input  logic [DATA_W-1:0] In0,
   input  logic              WriteEnable1,
   input  logic [ADDR_W-1:0] SelectIn1,
   input  logic [DATA_W-1:0] In1,
   input  logic              ReserveEnable,
   input  logic [ADDR_W-1:0] SelectReserve,
   input  logic [ADDR_W-1:0] SelectA,
   input  logic [ADDR_W-1:0] SelectB,
   output logic [DATA_W-1:0] A,
   output logic [DATA_W-1:0] B,
   output logic              BusyA,
   output logic              BusyB
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DEPTH-1:0]  r_busy;

   logic              w_we0;
   logic              w_we1;
   logic              w_rsv;
   logic              w_zero_a;
   logic              w_zero_b;
   logic [DEPTH-1:0]  w_busy_next;
   logic [DATA_W-1:0] w_rd_a;
   logic [DATA_W-1:0] w_rd_b;

   // Address 0 is write- and reserve-immune when the zero register is enabled.
   assign w_we0    = WriteEnable0  && !(ZERO_REG && (SelectIn0 == '0));
   assign w_we1    = WriteEnable1  && !(ZERO_REG && (SelectIn1 == '0));
   assign w_rsv    = ReserveEnable && !(ZERO_REG && (SelectReserve == '0));
   assign w_zero_a = ZERO_REG && (SelectA == '0);
   assign w_zero_b = ZERO_REG && (SelectB == '0);

   // Writes clear busy first; a same-cycle reserve then re-arms it.
   always_comb begin
      w_busy_next = r_busy;
      for (int i = 0; i < DEPTH; i++) begin
         if ((w_we0 && (SelectIn0 == ADDR_W'(i))) || (w_we1 && (SelectIn1 == ADDR_W'(i))))
            w_busy_next[i] = 1'b0;
         if (w_rsv && (SelectReserve == ADDR_W'(i)))
            w_busy_next[i] = 1'b1;
      end
   end

   always_comb begin
      w_rd_a = r_mem[SelectA];
      if (w_we0 && (SelectIn0 == SelectA)) w_rd_a = In0;
      if (w_we1 && (SelectIn1 == SelectA)) w_rd_a = In1;
      if (w_zero_a)                        w_rd_a = '0;
   end

   always_comb begin
      w_rd_b = r_mem[SelectB];
      if (w_we0 && (SelectIn0 == SelectB)) w_rd_b = In0;
      if (w_we1 && (SelectIn1 == SelectB)) w_rd_b = In1;
      if (w_zero_b)                        w_rd_b = '0;
   end

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_busy <= '0;
         A      <= '0;
         B      <= '0;
         BusyA  <= 1'b0;
         BusyB  <= 1'b0;
      end else begin
         if (w_we0) r_mem[SelectIn0] <= In0;
         if (w_we1) r_mem[SelectIn1] <= In1;
         r_busy <= w_busy_next;
         A      <= w_rd_a;
         B      <= w_rd_b;
         BusyA  <= w_busy_next[SelectA];
         BusyB  <= w_busy_next[SelectB];
      end
   end

endmodule

// File: tb/tb_regfile_pipe.sv
// Bench for regfile_pipe: one instance without and one with the zero register,
// both driven identically and compared against an array-based model.
module tb_regfile_pipe;

   localparam int DW = 16;
   localparam int AW = 4;
   localparam int N  = 1 << AW;

   logic          Clock = 1'b0;
   logic          Reset;
   logic          we0, we1, rsv;
   logic [AW-1:0] s0, s1, sr, sa, sb;
   logic [DW-1:0] d0, d1;

   logic [DW-1:0] a_n, b_n, a_z, b_z;
   logic          ba_n, bb_n, ba_z, bb_z;

   logic [DW-1:0] mr [2][N];
   logic          mb [2][N];

   int n_cmp = 0;
   int n_err = 0;

   always #5 Clock = ~Clock;

   regfile_pipe #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b0)) u_dut_n (
      .Clock(Clock), .Reset(Reset),
      .WriteEnable0(we0), .SelectIn0(s0), .In0(d0),
      .WriteEnable1(we1), .SelectIn1(s1), .In1(d1),
      .ReserveEnable(rsv), .SelectReserve(sr),
      .SelectA(sa), .SelectB(sb),
      .A(a_n), .B(b_n), .BusyA(ba_n), .BusyB(bb_n)
   );

   regfile_pipe #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b1)) u_dut_z (
      .Clock(Clock), .Reset(Reset),
      .WriteEnable0(we0), .SelectIn0(s0), .In0(d0),
      .WriteEnable1(we1), .SelectIn1(s1), .In1(d1),
      .ReserveEnable(rsv), .SelectReserve(sr),
      .SelectA(sa), .SelectB(sb),
      .A(a_z), .B(b_z), .BusyA(ba_z), .BusyB(bb_z)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: apply port 0 then port 1 (port 1 wins), clear busy on writes,
   // then apply the reserve so it survives a same-cycle write.
   task automatic model_edge();
      for (int z = 0; z < 2; z++) begin
         if (!Reset) begin
            for (int i = 0; i < N; i++) begin
               mr[z][i] = '0;
               mb[z][i] = 1'b0;
            end
         end else begin
            if (we0 && !(z == 1 && s0 == 0)) begin mr[z][s0] = d0; mb[z][s0] = 1'b0; end
            if (we1 && !(z == 1 && s1 == 0)) begin mr[z][s1] = d1; mb[z][s1] = 1'b0; end
            if (rsv && !(z == 1 && sr == 0)) mb[z][sr] = 1'b1;
         end
      end
   endtask

   task automatic idle();
      we0 = 1'b0; we1 = 1'b0; rsv = 1'b0;
      s0 = '0; s1 = '0; sr = '0; d0 = '0; d1 = '0;
   endtask

   task automatic cycle();
      @(posedge Clock);
      model_edge();
      #1;
      chk("a_n",  {16'h0, a_n},  {16'h0, mr[0][sa]});
      chk("b_n",  {16'h0, b_n},  {16'h0, mr[0][sb]});
      chk("ba_n", {31'h0, ba_n}, {31'h0, mb[0][sa]});
      chk("bb_n", {31'h0, bb_n}, {31'h0, mb[0][sb]});
      chk("a_z",  {16'h0, a_z},  {16'h0, (sa == 0) ? 16'h0 : mr[1][sa]});
      chk("b_z",  {16'h0, b_z},  {16'h0, (sb == 0) ? 16'h0 : mr[1][sb]});
      chk("ba_z", {31'h0, ba_z}, {31'h0, (sa == 0) ? 1'b0 : mb[1][sa]});
      chk("bb_z", {31'h0, bb_z}, {31'h0, (sb == 0) ? 1'b0 : mb[1][sb]});
   endtask

   initial begin
      for (int z = 0; z < 2; z++)
         for (int i = 0; i < N; i++) begin mr[z][i] = '0; mb[z][i] = 1'b0; end
      idle();
      sa = '0; sb = '0;
      Reset = 1'b0;
      cycle();
      Reset = 1'b1;

      // Reset state
      sa = 4'd3; sb = 4'd15;
      cycle();
      chk("rst_a", {16'h0, a_n}, 32'h0);
      chk("rst_b", {16'h0, b_n}, 32'h0);
      chk("rst_busy", {30'h0, ba_n, bb_n}, 32'h0);

      // Forwarded write
      we0 = 1'b1; s0 = 4'd5; d0 = 16'hBEEF; sa = 4'd5;
      cycle();
      chk("fwd_a", {16'h0, a_n}, 32'hBEEF);
      idle();
      cycle();
      chk("hold_a", {16'h0, a_n}, 32'hBEEF);

      // Dual write collision
      we0 = 1'b1; s0 = 4'd7; d0 = 16'h1111;
      we1 = 1'b1; s1 = 4'd7; d1 = 16'h2222; sb = 4'd7;
      cycle();
      chk("coll_b", {16'h0, b_n}, 32'h2222);
      idle();
      cycle();
      chk("coll_hold", {16'h0, b_n}, 32'h2222);

      // Zero register
      we0 = 1'b1; s0 = 4'd0; d0 = 16'hFFFF; sa = 4'd0;
      cycle();
      chk("zero_a", {16'h0, a_z}, 32'h0);
      chk("nozero_a", {16'h0, a_n}, 32'hFFFF);
      idle();
      rsv = 1'b1; sr = 4'd0;
      cycle();
      chk("zero_busy", {31'h0, ba_z}, 32'h0);
      chk("nozero_busy", {31'h0, ba_n}, 32'h1);

      // Scoreboard
      idle();
      rsv = 1'b1; sr = 4'd9; sa = 4'd9;
      cycle();
      chk("sb_set", {31'h0, ba_n}, 32'h1);
      idle();
      we0 = 1'b1; s0 = 4'd9; d0 = 16'h0042;
      cycle();
      chk("sb_clr", {31'h0, ba_n}, 32'h0);
      chk("sb_clr_a", {16'h0, a_n}, 32'h0042);
      rsv = 1'b1; sr = 4'd9; d0 = 16'h0043;
      cycle();
      chk("sb_both", {31'h0, ba_n}, 32'h1);
      chk("sb_both_a", {16'h0, a_n}, 32'h0043);

      // Reset discards a same-cycle write
      idle();
      for (int i = 1; i <= 4; i++) begin
         we0 = 1'b1; s0 = AW'(i); d0 = DW'(16'h1000 + i);
         rsv = (i == 2); sr = 4'd2;
         cycle();
      end
      idle();
      Reset = 1'b0; we0 = 1'b1; s0 = 4'd1; d0 = 16'hAAAA;
      cycle();
      Reset = 1'b1; idle();
      for (int i = 1; i <= 4; i++) begin
         sa = AW'(i); sb = AW'(5 - i);
         cycle();
         chk("postrst_a", {16'h0, a_n}, 32'h0);
         chk("postrst_busy", {30'h0, ba_n, bb_n}, 32'h0);
      end

      // Randomized traffic with narrow address ranges to provoke collisions
      for (int k = 0; k < 600; k++) begin
         int hi;
         hi = ($urandom_range(0, 1) == 0) ? 3 : N - 1;
         Reset = ($urandom_range(0, 63) != 0);
         we0 = $urandom_range(0, 1); s0 = AW'($urandom_range(0, hi)); d0 = DW'($urandom);
         we1 = $urandom_range(0, 1); s1 = AW'($urandom_range(0, hi)); d1 = DW'($urandom);
         rsv = ($urandom_range(0, 2) == 0); sr = AW'($urandom_range(0, hi));
         sa = AW'($urandom_range(0, hi)); sb = AW'($urandom_range(0, hi));
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
